// File: rtl/match_index_drain.sv
// Drains the 9-bit match-index FIFO, maps each index to a rule ID and emits capped
// per-vector match records plus a trailer. Optional: MATCH_COUNT_EN puts the beat count on the trailer.
module match_index_drain #(
  parameter int RULE_W      = 16,
  parameter int MAX_MATCHES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              empty,
  output logic              rd_en,
  input  logic [8:0]        idx_din,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_addr,
  input  logic [RULE_W-1:0] cfg_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [RULE_W-1:0] m_rule_id,
  output logic              m_last,
  output logic              m_ovf
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOOK, S_EMIT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              trailer_q;
  logic [RULE_W-1:0] table_mem [256];
  logic [RULE_W-1:0] rd_data;
  logic [7:0]        rd_addr;
  logic              idx_zero;
  logic              accept;
  logic [RULE_W-1:0] trailer_id;

`ifdef MATCH_COUNT_EN
  assign trailer_id = RULE_W'(count_q);
`else
  assign trailer_id = '0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    m_valid   = (state == S_EMIT);
    idx_zero  = (idx_din == 9'd0);
    accept    = !idx_zero && (idx_din <= 9'd256) && (count_q < CNT_W'(MAX_MATCHES));
    rd_addr   = 8'(idx_din - 9'd1);
    case (state)
      S_IDLE: begin
        if (!empty) begin
          rd_en     = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = (idx_zero || accept) ? S_LOOK : S_IDLE;
      S_LOOK:  state_nxt = S_EMIT;
      S_EMIT: begin
        if (m_ready) begin
          rd_en     = !empty;
          state_nxt = empty ? S_IDLE : S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A record or read must never complete while reset is being applied.
    if (rst) begin
      rd_en   = 1'b0;
      m_valid = 1'b0;
    end
  end

  // NOTE: the rule table is configuration storage and is deliberately not reset;
  // non-blocking read and write in one process give read-first behaviour on collision.
  always_ff @(posedge clk) begin
    if (cfg_we) table_mem[cfg_addr] <= cfg_data;
    if (state == S_FETCH) rd_data <= table_mem[rd_addr];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      trailer_q <= 1'b0;
      m_rule_id <= '0;
      m_last    <= 1'b0;
      m_ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: begin
          trailer_q <= idx_zero;
          if (!idx_zero && !accept) ovf_q <= 1'b1;
        end
        S_LOOK: begin
          if (trailer_q) begin
            m_rule_id <= trailer_id;
            m_last    <= 1'b1;
            m_ovf     <= ovf_q;
            count_q   <= '0;
            ovf_q     <= 1'b0;
          end else begin
            m_rule_id <= rd_data;
            m_last    <= 1'b0;
            m_ovf     <= 1'b0;
            count_q   <= count_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
